// File: rtl/uart_mem_bridge_if.sv
// Memory port between the UART bridge and the SoC memory arbiter.
// The bridge drives requests (master); the arbiter answers (slave).
interface uart_mem_bridge_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/uart_mem_bridge.sv
// UART-to-memory debug bridge: parses 'W'/'R' command frames from the UART
// receiver, performs one 32-bit memory access and streams the reply bytes
// back through the UART transmitter. Unknown commands are answered with '?'.
module uart_mem_bridge #(
    parameter int TIMEOUT_CLK = 1200000
) (
    input  logic                      clk,
    input  logic                      n_reset,
    input  logic                      rx_ready_i,
    input  logic [7:0]                rx_data_i,
    output logic                      tx_write_o,
    output logic [7:0]                tx_data_o,
    input  logic                      tx_finished_i,
    uart_mem_bridge_if.master         mem,
    output logic                      busy_o
);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, MEM, TX} state_t;

    localparam int TW = (TIMEOUT_CLK > 2) ? $clog2(TIMEOUT_CLK) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CLK - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

    state_t        state_q, state_d;
    logic [1:0]    byteCnt_q, byteCnt_d;
    logic [2:0]    replyCnt_q, replyCnt_d;
    logic [2:0]    replyLen_q, replyLen_d;
    logic [31:0]   reply_q, reply_d;
    logic          inFlight_q, inFlight_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          memWe_q, memWe_d;
    logic [31:0]   memAddr_q, memAddr_d;
    logic [31:0]   memWdata_q, memWdata_d;
    logic          txWrite_q, txWrite_d;
    logic [7:0]    txData_q, txData_d;
    logic [2:0]    nextReplyCnt;

    // Next-state logic: frame parsing, memory handshake and reply sequencing.
    always_comb begin
        state_d      = state_q;
        byteCnt_d    = byteCnt_q;
        replyCnt_d   = replyCnt_q;
        replyLen_d   = replyLen_q;
        reply_d      = reply_q;
        inFlight_d   = inFlight_q;
        timer_d      = timer_q;
        memWe_d      = memWe_q;
        memAddr_d    = memAddr_q;
        memWdata_d   = memWdata_q;
        txWrite_d    = 1'b0;
        txData_d     = txData_q;
        nextReplyCnt = replyCnt_q + 3'd1;

        case (state_q)
            IDLE: begin
                if (rx_ready_i) begin
                    if (rx_data_i == 8'h57 || rx_data_i == 8'h52) begin
                        state_d   = ADDR;
                        byteCnt_d = 2'd0;
                        memWe_d   = (rx_data_i == 8'h57);
                        timer_d   = '0;
                    end else begin
                        state_d    = TX;
                        reply_d    = 32'h0000_003F;
                        replyLen_d = 3'd1;
                        replyCnt_d = 3'd0;
                        inFlight_d = 1'b0;
                    end
                end
            end
            ADDR, DATA: begin
                if (rx_ready_i) begin
                    if (state_q == ADDR) begin
                        memAddr_d[{byteCnt_q, 3'b000} +: 8] = rx_data_i;
                    end else begin
                        memWdata_d[{byteCnt_q, 3'b000} +: 8] = rx_data_i;
                    end
                    byteCnt_d = byteCnt_q + 2'd1;
                    timer_d   = '0;
                    if (byteCnt_q == 2'd3) begin
                        state_d = (state_q == ADDR && memWe_q) ? DATA : MEM;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            MEM: begin
                if (mem.mem_ready) begin
                    state_d    = TX;
                    replyCnt_d = 3'd0;
                    inFlight_d = 1'b1;
                    txWrite_d  = 1'b1;
                    if (memWe_q) begin
                        reply_d    = 32'h0000_004B;
                        replyLen_d = 3'd1;
                        txData_d   = 8'h4B;
                    end else begin
                        reply_d    = mem.mem_rdata;
                        replyLen_d = 3'd4;
                        txData_d   = mem.mem_rdata[7:0];
                    end
                end
            end
            TX: begin
                if (!inFlight_q) begin
                    txWrite_d  = 1'b1;
                    txData_d   = reply_q[{replyCnt_q[1:0], 3'b000} +: 8];
                    inFlight_d = 1'b1;
                end else if (tx_finished_i) begin
                    if (replyCnt_q == replyLen_q - 3'd1) begin
                        state_d    = IDLE;
                        inFlight_d = 1'b0;
                    end else begin
                        replyCnt_d = nextReplyCnt;
                        txWrite_d  = 1'b1;
                        txData_d   = reply_q[{nextReplyCnt[1:0], 3'b000} +: 8];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q    <= IDLE;
            byteCnt_q  <= 2'd0;
            replyCnt_q <= 3'd0;
            replyLen_q <= 3'd0;
            reply_q    <= 32'h0;
            inFlight_q <= 1'b0;
            timer_q    <= '0;
            memWe_q    <= 1'b0;
            memAddr_q  <= 32'h0;
            memWdata_q <= 32'h0;
            txWrite_q  <= 1'b0;
            txData_q   <= 8'h00;
        end else begin
            state_q    <= state_d;
            byteCnt_q  <= byteCnt_d;
            replyCnt_q <= replyCnt_d;
            replyLen_q <= replyLen_d;
            reply_q    <= reply_d;
            inFlight_q <= inFlight_d;
            timer_q    <= timer_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            txWrite_q  <= txWrite_d;
            txData_q   <= txData_d;
        end
    end

    assign mem.mem_req   = (state_q == MEM);
    assign mem.mem_we    = memWe_q;
    assign mem.mem_addr  = memAddr_q;
    assign mem.mem_wdata = memWdata_q;
    assign tx_write_o    = txWrite_q;
    assign tx_data_o     = txData_q;
    assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Directed testbench for uart_mem_bridge with a behavioural UART transmitter
// and a memory responder with programmable wait states.
module tb_uart_mem_bridge;

    localparam int TIMEOUT  = 50;
    localparam int UART_LAT = 5;

    logic       clk = 1'b0;
    logic       nReset = 1'b0;
    logic       rxReady = 1'b0;
    logic [7:0] rxData = 8'h00;
    logic       txWrite;
    logic [7:0] txData;
    logic       txFinished = 1'b0;
    logic       busy;

    uart_mem_bridge_if memBus();

    uart_mem_bridge #(.TIMEOUT_CLK(TIMEOUT)) dut (
        .clk           (clk),
        .n_reset       (nReset),
        .rx_ready_i    (rxReady),
        .rx_data_i     (rxData),
        .tx_write_o    (txWrite),
        .tx_data_o     (txData),
        .tx_finished_i (txFinished),
        .mem           (memBus),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lastRxCyc = 0;

    int          memDelay = 0;
    logic [31:0] memReadValue = 32'h0;
    int          reqAge = 0;
    int          memReqCycles = 0;
    int          memTxns = 0;
    int          memUnstable = 0;
    logic [31:0] lastAddr = 32'h0;
    logic [31:0] lastWdata = 32'h0;
    logic        lastWe = 1'b0;
    bit          prevReq = 1'b0;
    logic [31:0] prevAddr = 32'h0;
    logic [31:0] prevWdata = 32'h0;
    logic        prevWe = 1'b0;

    bit          uartBusy = 1'b0;
    int          uartLeft = 0;
    logic [7:0]  uartByte = 8'h00;
    int          txOverlap = 0;
    int          txUnstable = 0;
    logic [7:0]  txBytes[$];
    int          wrCyc[$];
    int          finCyc[$];

    // Memory responder, memory-port monitor and UART transmitter model, all sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        memBus.mem_ready = 1'b0;
        memBus.mem_rdata = 32'hxxxx_xxxx;
        if (memBus.mem_req === 1'b1) begin
            if (reqAge == memDelay) begin
                memBus.mem_ready = 1'b1;
                memBus.mem_rdata = memReadValue;
                reqAge = 0;
            end else begin
                reqAge++;
            end
            memReqCycles++;
            if (prevReq && (memBus.mem_addr !== prevAddr || memBus.mem_wdata !== prevWdata
                            || memBus.mem_we !== prevWe))
                memUnstable++;
            if (memBus.mem_ready) begin
                memTxns++;
                lastAddr  = memBus.mem_addr;
                lastWdata = memBus.mem_wdata;
                lastWe    = memBus.mem_we;
            end
        end else begin
            reqAge = 0;
        end
        prevReq   = (memBus.mem_req === 1'b1);
        prevAddr  = memBus.mem_addr;
        prevWdata = memBus.mem_wdata;
        prevWe    = memBus.mem_we;

        txFinished = 1'b0;
        if (uartBusy) begin
            if (txData !== uartByte) txUnstable++;
            uartLeft--;
            if (uartLeft == 0) begin
                txFinished = 1'b1;
                uartBusy   = 1'b0;
                finCyc.push_back(cyc);
            end
        end
        if (txWrite === 1'b1) begin
            if (uartBusy) txOverlap++;
            uartBusy = 1'b1;
            uartLeft = UART_LAT;
            uartByte = txData;
            txBytes.push_back(txData);
            wrCyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        lastRxCyc = cyc;
        rxReady   = 1'b1;
        rxData    = b;
        tick();
        rxReady   = 1'b0;
    endtask

    task automatic clearLogs();
        memReqCycles = 0;
        memTxns      = 0;
        txBytes.delete();
        wrCyc.delete();
        finCyc.delete();
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 500) begin
            tick();
            n++;
        end
        checkOutput(tag, {31'h0, busy}, 32'h0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_txw"},   {31'h0, txWrite}, 32'h0);
        checkOutput({tag, "_txd"},   {24'h0, txData}, 32'h0);
        checkOutput({tag, "_req"},   {31'h0, memBus.mem_req}, 32'h0);
        checkOutput({tag, "_we"},    {31'h0, memBus.mem_we}, 32'h0);
        checkOutput({tag, "_addr"},  memBus.mem_addr, 32'h0);
        checkOutput({tag, "_wdata"}, memBus.mem_wdata, 32'h0);
        checkOutput({tag, "_busy"},  {31'h0, busy}, 32'h0);
    endtask

    initial begin
        int t;
        int n;

        // Reset state
        repeat (3) tick();
        checkResetOutputs("reset");
        nReset = 1'b1;
        tick();

        // Zero-wait write: 57 00 10 00 00 EF BE AD DE
        clearLogs();
        memDelay = 0;
        applyStimulus(8'h57);
        applyStimulus(8'h00); applyStimulus(8'h10); applyStimulus(8'h00); applyStimulus(8'h00);
        applyStimulus(8'hEF); applyStimulus(8'hBE); applyStimulus(8'hAD); applyStimulus(8'hDE);
        checkOutput("wr_req",   {31'h0, memBus.mem_req}, 32'h1);
        checkOutput("wr_we",    {31'h0, memBus.mem_we}, 32'h1);
        checkOutput("wr_addr",  memBus.mem_addr, 32'h0000_1000);
        checkOutput("wr_wdata", memBus.mem_wdata, 32'hDEAD_BEEF);
        tick();
        checkOutput("wr_txw",     {31'h0, txWrite}, 32'h1);
        checkOutput("wr_txd",     {24'h0, txData}, 32'h4B);
        checkOutput("wr_req_off", {31'h0, memBus.mem_req}, 32'h0);
        waitIdle("wr_idle");
        checkOutput("wr_idle_cyc", cyc - finCyc[0], 32'd1);
        checkOutput("wr_txns",     memTxns, 32'd1);
        checkOutput("wr_reqcyc",   memReqCycles, 32'd1);
        checkOutput("wr_nbytes",   txBytes.size(), 32'd1);
        checkOutput("wr_reply",    {24'h0, txBytes[0]}, 32'h4B);

        // Read with mem_ready in the third request cycle
        clearLogs();
        memDelay     = 2;
        memReadValue = 32'h1234_5678;
        applyStimulus(8'h52);
        applyStimulus(8'h00); applyStimulus(8'h10); applyStimulus(8'h00); applyStimulus(8'h00);
        t = lastRxCyc;
        checkOutput("rd_req",  {31'h0, memBus.mem_req}, 32'h1);
        checkOutput("rd_we",   {31'h0, memBus.mem_we}, 32'h0);
        checkOutput("rd_addr", memBus.mem_addr, 32'h0000_1000);
        waitIdle("rd_idle");
        checkOutput("rd_reqcyc",  memReqCycles, 32'd3);
        checkOutput("rd_first_w", wrCyc[0] - t, 32'd4);
        checkOutput("rd_nbytes",  txBytes.size(), 32'd4);
        checkOutput("rd_b0", {24'h0, txBytes[0]}, 32'h78);
        checkOutput("rd_b1", {24'h0, txBytes[1]}, 32'h56);
        checkOutput("rd_b2", {24'h0, txBytes[2]}, 32'h34);
        checkOutput("rd_b3", {24'h0, txBytes[3]}, 32'h12);
        for (int i = 1; i < 4; i++)
            checkOutput($sformatf("rd_gap%0d", i), wrCyc[i] - finCyc[i-1], 32'd1);

        // Unknown command, then an immediate read
        clearLogs();
        memDelay     = 0;
        memReadValue = 32'hAABB_CCDD;
        applyStimulus(8'h41);
        checkOutput("unk_txw_t1", {31'h0, txWrite}, 32'h0);
        checkOutput("unk_busy",   {31'h0, busy}, 32'h1);
        tick();
        checkOutput("unk_txw_t2", {31'h0, txWrite}, 32'h1);
        checkOutput("unk_txd",    {24'h0, txData}, 32'h3F);
        waitIdle("unk_idle");
        checkOutput("unk_txns",   memTxns, 32'd0);
        checkOutput("unk_reqcyc", memReqCycles, 32'd0);
        checkOutput("unk_nbytes", txBytes.size(), 32'd1);
        clearLogs();
        applyStimulus(8'h52);
        checkOutput("unk_r_acc", {31'h0, busy}, 32'h1);
        applyStimulus(8'h00); applyStimulus(8'h20); applyStimulus(8'h00); applyStimulus(8'h00);
        waitIdle("unk_r_idle");
        checkOutput("unk_r_addr", lastAddr, 32'h0000_2000);
        checkOutput("unk_r_b0", {24'h0, txBytes[0]}, 32'hDD);
        checkOutput("unk_r_b3", {24'h0, txBytes[3]}, 32'hAA);

        // Inter-byte timeout, then a full write frame
        clearLogs();
        applyStimulus(8'h57); applyStimulus(8'h00); applyStimulus(8'h10);
        t = lastRxCyc;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        checkOutput("to_idle",   {31'h0, busy}, 32'h0);
        checkOutput("to_cycle",  cyc - t, TIMEOUT + 1);
        checkOutput("to_reqcyc", memReqCycles, 32'd0);
        checkOutput("to_ntx",    txBytes.size(), 32'd0);
        applyStimulus(8'h57);
        applyStimulus(8'h04); applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h00);
        applyStimulus(8'h44); applyStimulus(8'h33); applyStimulus(8'h22); applyStimulus(8'h11);
        waitIdle("to_wr_idle");
        checkOutput("to_wr_txns",  memTxns, 32'd1);
        checkOutput("to_wr_addr",  lastAddr, 32'h0000_0004);
        checkOutput("to_wr_wdata", lastWdata, 32'h1122_3344);
        checkOutput("to_wr_reply", {24'h0, txBytes[0]}, 32'h4B);

        // Bytes arriving exactly on the expiry cycle keep the frame alive
        clearLogs();
        memReadValue = 32'h5A5A_A5A5;
        applyStimulus(8'h52);
        repeat (TIMEOUT - 1) tick();
        applyStimulus(8'h00);
        repeat (TIMEOUT - 1) tick();
        applyStimulus(8'h30);
        repeat (TIMEOUT - 1) tick();
        applyStimulus(8'h00);
        repeat (TIMEOUT - 1) tick();
        applyStimulus(8'h00);
        checkOutput("edge_req", {31'h0, memBus.mem_req}, 32'h1);
        waitIdle("edge_idle");
        checkOutput("edge_addr", lastAddr, 32'h0000_3000);
        checkOutput("edge_b0", {24'h0, txBytes[0]}, 32'hA5);
        checkOutput("edge_b2", {24'h0, txBytes[2]}, 32'h5A);

        // Stray bytes during MEM and TX are dropped
        clearLogs();
        memDelay     = 3;
        memReadValue = 32'hCAFE_F00D;
        applyStimulus(8'h52);
        applyStimulus(8'h08); applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h00);
        applyStimulus(8'h55);
        n = 0;
        while (txWrite !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checkOutput("inj_txw_seen", {31'h0, txWrite}, 32'h1);
        tick();
        applyStimulus(8'h55);
        waitIdle("inj_idle");
        checkOutput("inj_txns",   memTxns, 32'd1);
        checkOutput("inj_reqcyc", memReqCycles, 32'd4);
        checkOutput("inj_addr",   lastAddr, 32'h0000_0008);
        checkOutput("inj_we",     {31'h0, lastWe}, 32'h0);
        checkOutput("inj_nbytes", txBytes.size(), 32'd4);
        checkOutput("inj_b0", {24'h0, txBytes[0]}, 32'h0D);
        checkOutput("inj_b1", {24'h0, txBytes[1]}, 32'hF0);
        checkOutput("inj_b2", {24'h0, txBytes[2]}, 32'hFE);
        checkOutput("inj_b3", {24'h0, txBytes[3]}, 32'hCA);
        repeat (3) tick();
        checkOutput("inj_stay_idle", {31'h0, busy}, 32'h0);
        checkOutput("inj_no_extra",  txBytes.size(), 32'd4);

        // Reset while a write is waiting in MEM
        clearLogs();
        memDelay = 1000;
        applyStimulus(8'h57);
        applyStimulus(8'h0C); applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h00);
        applyStimulus(8'h78); applyStimulus(8'h56); applyStimulus(8'h34); applyStimulus(8'h12);
        checkOutput("rst_req_before", {31'h0, memBus.mem_req}, 32'h1);
        tick();
        tick();
        nReset = 1'b0;
        tick();
        checkResetOutputs("rst_mid");
        nReset       = 1'b1;
        memDelay     = 0;
        memReadValue = 32'h0BAD_C0DE;
        tick();
        applyStimulus(8'h52);
        applyStimulus(8'h0C); applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h00);
        waitIdle("rst_rd_idle");
        checkOutput("rst_txns", memTxns, 32'd1);
        checkOutput("rst_we",   {31'h0, lastWe}, 32'h0);
        checkOutput("rst_addr", lastAddr, 32'h0000_000C);
        checkOutput("rst_b0", {24'h0, txBytes[0]}, 32'hDE);
        checkOutput("rst_b1", {24'h0, txBytes[1]}, 32'hC0);
        checkOutput("rst_b2", {24'h0, txBytes[2]}, 32'hAD);
        checkOutput("rst_b3", {24'h0, txBytes[3]}, 32'h0B);

        // Protocol invariants collected over the whole run
        checkOutput("tx_overlap",   txOverlap, 32'd0);
        checkOutput("tx_unstable",  txUnstable, 32'd0);
        checkOutput("mem_unstable", memUnstable, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
